// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state, hazard cause encoding and per-cause register control vectors.
package pipe_ctrl_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INIT_CNT_W = 8;

    typedef enum logic [1:0] {
        StInit,
        StRun,
        StMemWait,
        StHalt
    } pipe_state_t;

    typedef enum logic [1:0] {
        HzNone,
        HzMem,
        HzBranch,
        HzLoadUse
    } hz_cause_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_flush;
        logic ex_mem_en;
        logic ex_mem_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CtrlFlushAll = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    localparam pipe_ctrl_t CtrlFreeze   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CtrlNormal   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam pipe_ctrl_t CtrlBranch   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    // Hold PC and IF/ID, push a bubble into ID/EX while the load moves on to MEM.
    localparam pipe_ctrl_t CtrlLoadUse  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};

    function automatic pipe_ctrl_t ctrl_for_cause(hz_cause_t cause);
        pipe_ctrl_t ctrl;
        unique case (cause)
            HzMem:     ctrl = CtrlFreeze;
            HzBranch:  ctrl = CtrlBranch;
            HzLoadUse: ctrl = CtrlLoadUse;
            HzNone:    ctrl = CtrlNormal;
        endcase
        return ctrl;
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard controller signal bundle: master = pipeline side, slave = controller.
// PIPE_HAZARD_PERF_EN adds the two performance counter outputs.
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [REG_ADDR_W-1:0] id_rs1_addr;
    logic [REG_ADDR_W-1:0] id_rs2_addr;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rd_addr;
    logic                  ex_mem_read;
    logic                  branch_taken;
    logic                  mem_busy;

    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic ex_mem_flush;
    logic stall_timeout;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_flush_cnt;
`endif

    modport master (
        output id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        output ex_rd_addr, ex_mem_read, branch_taken, mem_busy,
        input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        input  ex_mem_en, ex_mem_flush, stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_rs1_addr, id_rs2_addr, id_rs1_used, id_rs2_used,
        input  ex_rd_addr, ex_mem_read, branch_taken, mem_busy,
        output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush,
        output ex_mem_en, ex_mem_flush, stall_timeout
`ifdef PIPE_HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/load_use_detect.sv
// Flags a load in EX whose destination is read by the instruction in ID.
// x0 is never a hazard since it is hardwired to zero.
module load_use_detect
    import pipe_ctrl_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    input  logic                  rs1_used_i,
    input  logic                  rs2_used_i,
    input  logic [REG_ADDR_W-1:0] rd_addr_i,
    input  logic                  mem_read_i,
    output logic                  load_use_o
);

    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit    = rs1_used_i && (rs1_addr_i == rd_addr_i);
        rs2_hit    = rs2_used_i && (rs2_addr_i == rd_addr_i);
        load_use_o = mem_read_i && (rd_addr_i != '0) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for IF/ID, ID/EX and EX/MEM plus PC enable, with stall watchdog.
// Optional PIPE_HAZARD_PERF_EN adds stall-cycle and branch-redirect counters.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned INIT_FLUSH_CYCLES = 3,
    parameter int unsigned MAX_STALL         = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    pipe_hazard_ctrl_if.slave hz
);

    localparam int unsigned          StallW   = $clog2(MAX_STALL + 1);
    localparam logic [StallW-1:0]    StallMax = StallW'(MAX_STALL);
    localparam logic [INIT_CNT_W-1:0] InitLast = INIT_CNT_W'(INIT_FLUSH_CYCLES - 1);

    pipe_state_t           state_q;
    logic [INIT_CNT_W-1:0] init_cnt_q;
    logic [StallW-1:0]     stall_cnt_q;
    logic                  stall_timeout_q;
    logic                  load_use;
    hz_cause_t             cause;
    pipe_ctrl_t            ctrl;

    load_use_detect u_load_use_detect (
        .rs1_addr_i (hz.id_rs1_addr),
        .rs2_addr_i (hz.id_rs2_addr),
        .rs1_used_i (hz.id_rs1_used),
        .rs2_used_i (hz.id_rs2_used),
        .rd_addr_i  (hz.ex_rd_addr),
        .mem_read_i (hz.ex_mem_read),
        .load_use_o (load_use)
    );

    // MEM_WAIT shares RUN's decode so a released stall services held hazards the same cycle.
    always_comb begin
        cause = HzNone;
        ctrl  = CtrlFlushAll;
        unique case (state_q)
            StInit: ctrl = CtrlFlushAll;
            StRun, StMemWait: begin
                if (hz.mem_busy) begin
                    cause = HzMem;
                end else if (hz.branch_taken) begin
                    cause = HzBranch;
                end else if (load_use) begin
                    cause = HzLoadUse;
                end
                ctrl = ctrl_for_cause(cause);
            end
            StHalt: ctrl = CtrlFreeze;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StInit;
            init_cnt_q      <= '0;
            stall_cnt_q     <= '0;
            stall_timeout_q <= 1'b0;
        end else begin
            unique case (state_q)
                StInit: begin
                    if (init_cnt_q == InitLast) begin
                        state_q    <= StRun;
                        init_cnt_q <= '0;
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                StRun: begin
                    if (hz.mem_busy) begin
                        state_q     <= StMemWait;
                        stall_cnt_q <= StallW'(1);
                    end
                end
                StMemWait: begin
                    if (!hz.mem_busy) begin
                        state_q     <= StRun;
                        stall_cnt_q <= '0;
                    end else if (stall_cnt_q == StallMax) begin
                        state_q         <= StHalt;
                        stall_timeout_q <= 1'b1;
                    end else if (stall_cnt_q != '1) begin
                        stall_cnt_q <= stall_cnt_q + 1'b1;
                    end
                end
                StHalt: state_q <= StHalt;
            endcase
        end
    end

    assign hz.pc_en         = ctrl.pc_en;
    assign hz.if_id_en      = ctrl.if_id_en;
    assign hz.if_id_flush   = ctrl.if_id_flush;
    assign hz.id_ex_en      = ctrl.id_ex_en;
    assign hz.id_ex_flush   = ctrl.id_ex_flush;
    assign hz.ex_mem_en     = ctrl.ex_mem_en;
    assign hz.ex_mem_flush  = ctrl.ex_mem_flush;
    assign hz.stall_timeout = stall_timeout_q;

`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else if (state_q == StRun || state_q == StMemWait) begin
            if (!ctrl.pc_en) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
            if (cause == HzBranch) begin
                perf_flush_q <= perf_flush_q + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = perf_stall_q;
    assign hz.perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: stimulus lists per scenario, a behavioural
// reference model feeds a scoreboard queue, and DUT outputs are compared mid low-phase.
module tb_pipe_hazard_ctrl;

    localparam int unsigned InitCycles = 3;
    localparam int unsigned MaxStall   = 4;

    // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, ex_mem_flush, timeout}
    localparam logic [7:0] ExpFlush   = 8'b0010_1010;
    localparam logic [7:0] ExpFreeze  = 8'b0000_0000;
    localparam logic [7:0] ExpNormal  = 8'b1101_0100;
    localparam logic [7:0] ExpBranch  = 8'b1111_1100;
    localparam logic [7:0] ExpLoadUse = 8'b0001_1100;

    typedef struct packed {
        logic       rst_n;
        logic       busy;
        logic       br;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
    } stim_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [7:0] sb[$];

    // Reference model state: 0 init, 1 run, 2 mem wait, 3 halt
    int m_state;
    int m_icnt;
    int m_scnt;
    bit m_to;

    pipe_hazard_ctrl_if hz_if ();

    pipe_hazard_ctrl #(
        .INIT_FLUSH_CYCLES (InitCycles),
        .MAX_STALL         (MaxStall)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hz_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic r, logic busy, logic br, logic mr, int rd,
                                 int rs1, logic u1, int rs2, logic u2);
        stim_t s;
        s.rst_n = r;
        s.busy  = busy;
        s.br    = br;
        s.mr    = mr;
        s.rd    = 5'(rd);
        s.rs1   = 5'(rs1);
        s.u1    = u1;
        s.rs2   = 5'(rs2);
        s.u2    = u2;
        return s;
    endfunction

    function automatic stim_t idle();
        return mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0);
    endfunction

    function logic [7:0] model_step(input stim_t s);
        logic [7:0] out;
        bit         lu;
        lu = s.mr && (s.rd != 5'd0) &&
             ((s.u1 && s.rs1 == s.rd) || (s.u2 && s.rs2 == s.rd));
        out = ExpFreeze;
        if (!s.rst_n) begin
            m_state = 0;
            m_icnt  = 0;
            m_scnt  = 0;
            m_to    = 1'b0;
            return ExpFlush;
        end
        case (m_state)
            0: begin
                out = ExpFlush;
                if (m_icnt == int'(InitCycles) - 1) begin
                    m_state = 1;
                    m_icnt  = 0;
                end else begin
                    m_icnt++;
                end
            end
            1, 2: begin
                if (s.busy) begin
                    out = ExpFreeze;
                    if (m_state == 1) begin
                        m_state = 2;
                        m_scnt  = 1;
                    end else if (m_scnt == int'(MaxStall)) begin
                        m_state = 3;
                    end else begin
                        m_scnt++;
                    end
                end else begin
                    out     = s.br ? ExpBranch : (lu ? ExpLoadUse : ExpNormal);
                    m_state = 1;
                    m_scnt  = 0;
                end
            end
            default: out = ExpFreeze;
        endcase
        out[0] = m_to;
        if (m_state == 3) m_to = 1'b1;
        return out;
    endfunction

    task automatic cyc(input stim_t s);
        @(negedge clk);
        rst_n               = s.rst_n;
        hz_if.mem_busy      = s.busy;
        hz_if.branch_taken  = s.br;
        hz_if.ex_mem_read   = s.mr;
        hz_if.ex_rd_addr    = s.rd;
        hz_if.id_rs1_addr   = s.rs1;
        hz_if.id_rs1_used   = s.u1;
        hz_if.id_rs2_addr   = s.rs2;
        hz_if.id_rs2_used   = s.u2;
        #2;
    endtask

    function automatic logic [7:0] outs();
        return {hz_if.pc_en, hz_if.if_id_en, hz_if.if_id_flush, hz_if.id_ex_en,
                hz_if.id_ex_flush, hz_if.ex_mem_en, hz_if.ex_mem_flush, hz_if.stall_timeout};
    endfunction

    task automatic test_reset();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(mk(1'b0, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5, 3, 1'b1, 5, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 7, 3, 1'b1, 5, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 9, 9, 1'b1, 2, 1'b0));
        st.push_back(idle());
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1, 0, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 5, 3, 1'b1, 5, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 5, 5, 1'b1, 5, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 6, 4, 1'b1, 7, 1'b1));
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL load_use step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_branch_priority();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b1, 5, 3, 1'b1, 5, 1'b1));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL branch_priority step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        for (int i = 0; i < 4; i++) st.push_back(mk(1'b1, 1'b1, 1'b1, 1'b1, 5, 5, 1'b1, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL mem_wait step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8, 8, 1'b1, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b1, 8, 8, 1'b1, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b1, 8, 8, 1'b1, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b1, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(mk(1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        for (int i = 0; i < 5; i++) st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t      st[$];
        logic [7:0] exp;
        logic [7:0] obs;
        for (int i = 0; i < 10; i++) st.push_back(mk(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(mk(1'b1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout step %0d: got %b expected %b", i, obs, exp);
            end
        end
        // Sticky flag and frozen pipe after busy drops, independent of the model.
        checks++;
        if (outs() !== 8'b0000_0001) begin
            errors++;
            $display("FAIL timeout_halt_hold: got %b expected %b", outs(), 8'b0000_0001);
        end
        st.delete();
        st.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 1'b0, 0, 1'b0));
        for (int i = 0; i < 4; i++) st.push_back(idle());
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i]);
            sb.push_back(model_step(st[i]));
            obs = outs();
            exp = sb.pop_front();
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL timeout_reset step %0d: got %b expected %b", i, obs, exp);
            end
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        m_state = 0;
        m_icnt  = 0;
        m_scnt  = 0;
        m_to    = 1'b0;
        rst_n   = 1'b0;
        hz_if.mem_busy     = 1'b0;
        hz_if.branch_taken = 1'b0;
        hz_if.ex_mem_read  = 1'b0;
        hz_if.ex_rd_addr   = '0;
        hz_if.id_rs1_addr  = '0;
        hz_if.id_rs1_used  = 1'b0;
        hz_if.id_rs2_addr  = '0;
        hz_if.id_rs2_used  = 1'b0;

        test_reset();
        test_load_use();
        test_branch_priority();
        test_mem_wait();
        test_back_to_back();
        test_timeout();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
